multicycle_controller: RTL and testbench

//  Multicycle MIPS control FSM; successor to the single-cycle combinational decoder.

---
 rtl/mc_pkg.sv | 67 ++++++
 rtl/mc_if.sv | 48 ++++
 rtl/mc_alu_decode.sv | 24 ++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS controller.
//   - state_e    : FSM state encodings (also exported on the debug state port)
//   - OP_* / FN_*: opcode and R-type funct values understood by the controller
//   - ALU_*      : aluctrl codes
//   - MX_* / MC_*: bit positions inside muxctrl / memctrl
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEMADDR  = 4'd6,
    S_MEMREAD  = 4'd7,
    S_MEMWRITE = 4'd8,
    S_MEMWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // muxctrl bit positions
  localparam int MX_ALUSRCA  = 0;
  localparam int MX_REGDST   = 1;
  localparam int MX_ALUSRCB  = 2;  // two bits wide
  localparam int MX_MEMTOREG = 4;
  localparam int MX_IORD     = 5;
  localparam int MX_PCSRC    = 6;

  // ALUSrcB selections
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // memctrl bit positions
  localparam int MC_REGWR = 0;
  localparam int MC_MEMWR = 1;
  localparam int MC_MEMRD = 2;

  // States in which the FSM waits on mem_ready and the watchdog runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> instruction register / datapath / memory bundle.
//   op, func       : instruction fields from the instruction register
//   zero           : ALU zero flag
//   mem_ready      : memory completes the access this cycle
//   muxctrl        : datapath mux selects
//   memctrl        : {mem_read, mem_write, reg_write}
//   aluctrl        : ALU operation
//   pc_write       : PC load enable
//   ir_write       : IR load enable
//   mem_timeout    : one-cycle watchdog pulse
//   state          : debug view of the FSM state
//   illegal_op     : sticky trap flag, present only with MC_ILLEGAL_TRAP_EN
// modport master = controller side, slave = datapath side.
interface mc_if #(
  parameter int MUX_W = 7,
  parameter int ALU_W = 4
);
  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic [MUX_W-1:0] muxctrl;
  logic [2:0]       memctrl;
  logic [ALU_W-1:0] aluctrl;
  logic             pc_write;
  logic             ir_write;
  logic             mem_timeout;
  logic [3:0]       state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic             illegal_op;
`endif

  modport master (
    input  op, func, zero, mem_ready,
    output muxctrl, memctrl, aluctrl, pc_write, ir_write, mem_timeout, state
`ifdef MC_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  muxctrl, memctrl, aluctrl, pc_write, ir_write, mem_timeout, state
`ifdef MC_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );
endinterface

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: R-type funct -> aluctrl code.
//   func_i    : funct field
//   alu_o     : ALU code (add for anything unsupported)
//   illegal_o : funct is not one of add/sub/and/or/slt
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [3:0] alu_o,
  output logic       illegal_o
);
  always_comb begin
    alu_o     = ALU_ADD;
    illegal_o = 1'b0;
    case (func_i)
      FN_ADD:  alu_o = ALU_ADD;
      FN_SUB:  alu_o = ALU_SUB;
      FN_AND:  alu_o = ALU_AND;
      FN_OR:   alu_o = ALU_OR;
      FN_SLT:  alu_o = ALU_SLT;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS control FSM.
//   FETCH -> DECODE -> EXEC/MEM -> WB, stalling on mem_ready in FETCH,
//   MEMREAD and MEMWRITE, with a watchdog that abandons a stuck access.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; forces every output to 0 while high
//   bus    : mc_if.master (op/func/zero/mem_ready in, controls out)
// Parameters: MUX_W (muxctrl width, >= 7), ALU_W (aluctrl width),
//   WAIT_W (watchdog width; timeout after 2**WAIT_W-1 stalled cycles).
// Build option: MC_ILLEGAL_TRAP_EN -- unsupported op/funct enters a TRAP
//   state with sticky illegal_op; otherwise such instructions act as NOPs.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MUX_W  = 7,
  parameter int ALU_W  = 4,
  parameter int WAIT_W = 4
) (
  input logic  clk,
  input logic  reset,
  mc_if.master bus
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_e ILL_NEXT = S_TRAP;
`else
  localparam state_e ILL_NEXT = S_FETCH;
`endif

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d, func_q, func_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              in_wait, timeout;
  logic [3:0]        fn_alu;
  logic              fn_illegal;

  logic [MUX_W-1:0]  mux_c;
  logic [2:0]        mem_c;
  logic [3:0]        alu_c;
  logic              pcw_c, irw_c;

  // Fed with func_d so the same decoder serves both the DECODE legality
  // check (live func) and EXEC_R (latched func_q).
  mc_alu_decode u_alu_dec (
    .func_i    (func_d),
    .alu_o     (fn_alu),
    .illegal_o (fn_illegal)
  );

  assign in_wait = is_wait_state(state_q);
  assign timeout = in_wait && (wait_q == WAIT_MAX);

  always_comb begin
    op_d   = op_q;
    func_d = func_q;
    if (state_q == S_DECODE) begin
      op_d   = bus.op;
      func_d = bus.func;
    end
  end

  // Next state and watchdog. The counter only survives cycles that stay in
  // a wait state, so any transition (or a timeout) clears it.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    if (in_wait && !bus.mem_ready && !timeout) wait_d = wait_q + WAIT_W'(1);
    case (state_q)
      S_FETCH: begin
        if (!timeout && bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (bus.op)
          OP_RTYPE:     state_d = fn_illegal ? ILL_NEXT : S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILL_NEXT;
        endcase
      end
      S_EXEC_R:  state_d = S_WB_R;
      S_WB_R:    state_d = S_FETCH;
      S_EXEC_I:  state_d = S_WB_I;
      S_WB_I:    state_d = S_FETCH;
      S_MEMADDR: state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (timeout)            state_d = S_FETCH;
        else if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (timeout || bus.mem_ready) state_d = S_FETCH;
      end
      S_MEMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode. Only the FETCH write enables (mem_ready) and the BRANCH
  // pc_write (zero) look at live inputs; everything else is state/op_q/func_q.
  // A timeout cycle drops the access entirely: no read, no write, no load.
  always_comb begin
    mux_c = '0;
    mem_c = '0;
    alu_c = ALU_ADD;
    pcw_c = 1'b0;
    irw_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        mux_c[MX_ALUSRCB +: 2] = SRCB_FOUR;
        if (!timeout) begin
          mem_c[MC_MEMRD] = 1'b1;
          pcw_c           = bus.mem_ready;
          irw_c           = bus.mem_ready;
        end
      end
      S_DECODE: mux_c[MX_ALUSRCB +: 2] = SRCB_BOFF;
      S_EXEC_R: begin
        mux_c[MX_ALUSRCA]      = 1'b1;
        mux_c[MX_ALUSRCB +: 2] = SRCB_REG;
        alu_c                  = fn_alu;
      end
      S_WB_R: begin
        mux_c[MX_REGDST] = 1'b1;
        mem_c[MC_REGWR]  = 1'b1;
      end
      S_EXEC_I, S_MEMADDR: begin
        mux_c[MX_ALUSRCA]      = 1'b1;
        mux_c[MX_ALUSRCB +: 2] = SRCB_IMM;
      end
      S_WB_I: mem_c[MC_REGWR] = 1'b1;
      S_MEMREAD: begin
        mux_c[MX_IORD] = 1'b1;
        if (!timeout) mem_c[MC_MEMRD] = 1'b1;
      end
      S_MEMWRITE: begin
        mux_c[MX_IORD] = 1'b1;
        if (!timeout) mem_c[MC_MEMWR] = 1'b1;
      end
      S_MEMWB: begin
        mux_c[MX_MEMTOREG] = 1'b1;
        mem_c[MC_REGWR]    = 1'b1;
      end
      S_BRANCH: begin
        mux_c[MX_ALUSRCA] = 1'b1;
        mux_c[MX_PCSRC]   = 1'b1;
        alu_c             = ALU_SUB;
        pcw_c             = bus.zero;
      end
      S_JUMP: begin
        mux_c[MX_PCSRC] = 1'b1;
        pcw_c           = 1'b1;
      end
      S_TRAP:  alu_c = '0;
      default: alu_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      wait_q  <= wait_d;
    end
  end

  // Reset overrides every output combinationally, including the cycle in
  // which it is first sampled.
  assign bus.muxctrl     = reset ? '0 : mux_c;
  assign bus.memctrl     = reset ? '0 : mem_c;
  assign bus.aluctrl     = reset ? '0 : ALU_W'(alu_c);
  assign bus.pc_write    = !reset && pcw_c;
  assign bus.ir_write    = !reset && irw_c;
  assign bus.mem_timeout = !reset && timeout;
  assign bus.state       = reset ? 4'd0 : 4'(state_q);
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal_op  = !reset && (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  logic clk;
  logic reset;

  mc_if #(.MUX_W(7), .ALU_W(4)) bus ();

  multicycle_controller #(.MUX_W(7), .ALU_W(4), .WAIT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: stimulus to drive plus outputs the spec demands.
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] func;
    logic       mr;
    logic       z;
    logic [3:0] st;
    logic [6:0] mux;
    logic [2:0] mem;
    logic [3:0] alu;
    logic       pcw, irw, to, ill;
  } ent_t;

  typedef struct {
    logic [3:0] st;
    logic [6:0] mux;
    logic [2:0] mem;
    logic [3:0] alu;
    logic       pcw, irw, to, ill;
  } snap_t;

  int    nchk = 0;
  int    nerr = 0;
  ent_t  pend[$];
  snap_t hist[$];
  ent_t  cur;
  bit    cur_vld = 0;
  snap_t s_now;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rfunc(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state st, from the control table.
  function automatic ent_t mk(input int st, input logic mr, input logic z, input logic to,
                              input logic [5:0] op, input logic [5:0] func);
    ent_t e;
    e.rst = 1'b0; e.op = op; e.func = func; e.mr = mr; e.z = z;
    e.st = 4'(st); e.mux = 7'b0; e.mem = 3'b0; e.alu = 4'b0010;
    e.pcw = 1'b0; e.irw = 1'b0; e.to = to; e.ill = 1'b0;
    case (st)
      0:  begin e.mux = 7'b0000100; if (!to) begin e.mem = 3'b100; e.pcw = mr; e.irw = mr; end end
      1:  e.mux = 7'b0001100;
      2:  begin e.mux = 7'b0000001; e.alu = rfunc(func); end
      3:  begin e.mux = 7'b0000010; e.mem = 3'b001; end
      4:  e.mux = 7'b0001001;
      5:  e.mem = 3'b001;
      6:  e.mux = 7'b0001001;
      7:  begin e.mux = 7'b0100000; if (!to) e.mem = 3'b100; end
      8:  begin e.mux = 7'b0100000; if (!to) e.mem = 3'b010; end
      9:  begin e.mux = 7'b0010000; e.mem = 3'b001; end
      10: begin e.mux = 7'b1000001; e.alu = 4'b0110; e.pcw = z; end
      11: begin e.mux = 7'b1000000; e.pcw = 1'b1; end
      12: begin e.alu = 4'b0000; e.ill = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ent_t mk_rst();
    ent_t e;
    e = mk(0, 1'b0, 1'b0, 1'b0, 6'b0, 6'b0);
    e.rst = 1'b1; e.mux = 7'b0; e.mem = 3'b0; e.alu = 4'b0; e.pcw = 1'b0; e.irw = 1'b0;
    return e;
  endfunction

  // Expand one instruction into its cycle sequence from the opcode rules.
  task automatic instr(input logic [5:0] op, input logic [5:0] func, input int fst,
                       input int mst, input logic z);
    bit legal_fn;
    bit illegal;
    legal_fn = (func == 6'b100000) || (func == 6'b100010) || (func == 6'b100100) ||
               (func == 6'b100101) || (func == 6'b101010);
    illegal  = 1'b0;
    for (int i = 0; i < fst; i++) pend.push_back(mk(0, 1'b0, z, 1'b0, op, func));
    pend.push_back(mk(0, 1'b1, z, 1'b0, op, func));
    pend.push_back(mk(1, 1'b1, z, 1'b0, op, func));
    case (op)
      6'b000000: begin
        if (legal_fn) begin
          pend.push_back(mk(2, 1'b1, z, 1'b0, op, func));
          pend.push_back(mk(3, 1'b1, z, 1'b0, op, func));
        end else illegal = 1'b1;
      end
      6'b100011: begin
        pend.push_back(mk(6, 1'b1, z, 1'b0, op, func));
        for (int i = 0; i < mst; i++) pend.push_back(mk(7, 1'b0, z, 1'b0, op, func));
        pend.push_back(mk(7, 1'b1, z, 1'b0, op, func));
        pend.push_back(mk(9, 1'b1, z, 1'b0, op, func));
      end
      6'b101011: begin
        pend.push_back(mk(6, 1'b1, z, 1'b0, op, func));
        for (int i = 0; i < mst; i++) pend.push_back(mk(8, 1'b0, z, 1'b0, op, func));
        pend.push_back(mk(8, 1'b1, z, 1'b0, op, func));
      end
      6'b001000: begin
        pend.push_back(mk(4, 1'b1, z, 1'b0, op, func));
        pend.push_back(mk(5, 1'b1, z, 1'b0, op, func));
      end
      6'b000100: pend.push_back(mk(10, 1'b1, z, 1'b0, op, func));
      6'b000010: pend.push_back(mk(11, 1'b1, z, 1'b0, op, func));
      default:   illegal = 1'b1;
    endcase
`ifdef MC_ILLEGAL_TRAP_EN
    if (illegal) begin
      for (int i = 0; i < 4; i++) pend.push_back(mk(12, 1'b1, z, 1'b0, op, func));
      pend.push_back(mk_rst());
    end
`else
    if (illegal) pend.push_back(mk(0, 1'b0, z, 1'b0, op, func));
`endif
  endtask

  task automatic play();
    ent_t e;
    while (pend.size() > 0) begin
      e = pend.pop_front();
      @(posedge clk); #1;
      reset         = e.rst;
      bus.op        = e.op;
      bus.func      = e.func;
      bus.mem_ready = e.mr;
      bus.zero      = e.z;
      cur           = e;
      cur_vld       = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  // Compare process: every driven cycle, DUT vs model.
  always @(negedge clk) begin
    if (cur_vld) begin
      s_now.st  = bus.state;
      s_now.mux = bus.muxctrl;
      s_now.mem = bus.memctrl;
      s_now.alu = bus.aluctrl;
      s_now.pcw = bus.pc_write;
      s_now.irw = bus.ir_write;
      s_now.to  = bus.mem_timeout;
`ifdef MC_ILLEGAL_TRAP_EN
      s_now.ill = bus.illegal_op;
      chk("illegal_op", bus.illegal_op, cur.ill);
`else
      s_now.ill = 1'b0;
`endif
      hist.push_back(s_now);
      chk("state",       bus.state,       cur.st);
      chk("muxctrl",     bus.muxctrl,     cur.mux);
      chk("memctrl",     bus.memctrl,     cur.mem);
      chk("aluctrl",     bus.aluctrl,     cur.alu);
      chk("pc_write",    bus.pc_write,    cur.pcw);
      chk("ir_write",    bus.ir_write,    cur.irw);
      chk("mem_timeout", bus.mem_timeout, cur.to);
      chk("excl_wr",     bus.memctrl[0] & bus.memctrl[1], 0);
    end
  end

  initial begin
    int cnt;
    reset = 1'b1; bus.op = '0; bus.func = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;

    // reset state
    hist.delete();
    pend.push_back(mk_rst()); pend.push_back(mk_rst());
    play();
    chk("rst_state", hist[1].st, 0);
    chk("rst_mem",   hist[1].mem, 0);
    chk("rst_alu",   hist[1].alu, 0);

    // add: 0,1,2,3
    hist.delete();
    instr(6'b000000, 6'b100000, 0, 0, 1'b0); play();
    chk("add_len", hist.size(), 4);
    chk("add_fetch_irw", hist[0].irw, 1);
    chk("add_exec_st", hist[2].st, 2);
    chk("add_wb_st", hist[3].st, 3);
    chk("add_wb_mem", hist[3].mem, 3'b001);
    chk("add_wb_regdst", hist[3].mux[1], 1);
    chk("add_wb_alu", hist[3].alu, 4'b0010);

    hist.delete();
    instr(6'b000000, 6'b100010, 0, 0, 1'b0); play();
    chk("sub_alu", hist[2].alu, 4'b0110);
    instr(6'b000000, 6'b100100, 1, 0, 1'b0);
    instr(6'b000000, 6'b100101, 0, 0, 1'b1);
    instr(6'b000000, 6'b101010, 2, 0, 1'b0);
    play();

    // addi
    hist.delete();
    instr(6'b001000, 6'b000000, 0, 0, 1'b0); play();
    chk("addi_wb_st", hist[3].st, 5);
    chk("addi_wb_mem", hist[3].mem, 3'b001);

    // lw with 2 stall cycles in MEMREAD: 7 cycles
    hist.delete();
    instr(6'b100011, 6'b000000, 0, 2, 1'b0); play();
    chk("lw_len", hist.size(), 7);
    chk("lw_stall_st", hist[4].st, 7);
    chk("lw_wb_st", hist[6].st, 9);
    chk("lw_wb_mem", hist[6].mem, 3'b001);
    chk("lw_wb_memtoreg", hist[6].mux[4], 1);

    // sw, one fetch stall, one write stall
    hist.delete();
    instr(6'b101011, 6'b000000, 1, 1, 1'b0); play();
    chk("sw_len", hist.size(), 6);
    chk("sw_mw_mem", hist[5].mem, 3'b010);

    // beq taken / not taken, j
    hist.delete();
    instr(6'b000100, 6'b000000, 0, 0, 1'b1); play();
    chk("beq1_st", hist[2].st, 10);
    chk("beq1_pcw", hist[2].pcw, 1);
    hist.delete();
    instr(6'b000100, 6'b000000, 0, 0, 1'b0); play();
    chk("beq0_pcw", hist[2].pcw, 0);
    hist.delete();
    instr(6'b000010, 6'b000000, 0, 0, 1'b0); play();
    chk("j_pcw", hist[2].pcw, 1);

    // watchdog: mem_ready held low in FETCH
    hist.delete();
    for (int i = 0; i < 15; i++) pend.push_back(mk(0, 1'b0, 1'b0, 1'b0, 6'b000010, 6'b0));
    pend.push_back(mk(0, 1'b0, 1'b0, 1'b1, 6'b000010, 6'b0));
    instr(6'b000010, 6'b000000, 0, 0, 1'b0);
    play();
    cnt = 0;
    for (int i = 0; i < hist.size(); i++) cnt += int'(hist[i].to);
    chk("to_pulses", cnt, 1);
    chk("to_cycle16", hist[15].to, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += int'(hist[i].irw) + int'(hist[i].pcw);
    chk("to_no_load", cnt, 0);
    chk("to_after_st", hist[16].st, 0);
    chk("to_recover_j", hist[18].st, 11);

    // reset while stalled in MEMWRITE
    hist.delete();
    pend.push_back(mk(0, 1'b1, 1'b0, 1'b0, 6'b101011, 6'b0));
    pend.push_back(mk(1, 1'b1, 1'b0, 1'b0, 6'b101011, 6'b0));
    pend.push_back(mk(6, 1'b1, 1'b0, 1'b0, 6'b101011, 6'b0));
    pend.push_back(mk(8, 1'b0, 1'b0, 1'b0, 6'b101011, 6'b0));
    pend.push_back(mk(8, 1'b0, 1'b0, 1'b0, 6'b101011, 6'b0));
    pend.push_back(mk_rst());
    for (int i = 0; i < 3; i++) pend.push_back(mk(0, 1'b0, 1'b0, 1'b0, 6'b101011, 6'b0));
    play();
    chk("rstmw_pre_st", hist[4].st, 8);
    chk("rstmw_st", hist[5].st, 0);
    chk("rstmw_mem", hist[5].mem, 0);
    chk("rstmw_after_st", hist[6].st, 0);
    cnt = 0;
    for (int i = 5; i < hist.size(); i++) cnt += int'(hist[i].mem[1]);
    chk("rstmw_no_memwr", cnt, 0);

    // unsupported opcode
    hist.delete();
    instr(6'b111111, 6'b000000, 0, 0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
    play();
    chk("ill_trap_st", hist[2].st, 12);
    chk("ill_sticky", hist[5].ill, 1);
    chk("ill_trap_mem", hist[5].mem, 0);
`else
    pend.push_back(mk(0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b0));
    play();
    chk("ill_nop_st", hist[2].st, 0);
    cnt = 0;
    for (int i = 1; i < hist.size(); i++)
      cnt += int'(hist[i].pcw) + int'(hist[i].irw) + int'(hist[i].mem[0]) + int'(hist[i].mem[1]);
    chk("ill_nop_nowr", cnt, 0);
`endif

    // unsupported R-type funct, then a normal lw
    instr(6'b000000, 6'b000000, 0, 0, 1'b0);
    instr(6'b100011, 6'b000000, 3, 0, 1'b0);
    play();

    cur_vld = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
